// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single external memory port between the fetch stage (line refills)
// and the memory stage (loads/stores). Fixed priority with the data side first.
// An anti-starvation counter lets fetch win after STARVE_MAX consecutive data
// grants while fetch was waiting.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   if_*                  fetch requester: req/addr in; gnt/rdata/rvalid/done out
//   mem_*                 data requester: req/we/addr/wdata in; gnt/rdata/rvalid/done out
//   bus_*                 memory side: req/we/addr/len/wdata out; ack/rvalid/rdata/last in
//   protocol_err          sticky flag: bus_last disagreed with the beat count
//   dbg_state             current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 WRESP)
//
// Handshake: a requester raises req and holds it, with its address/data stable,
// until its done pulse. Requests are sampled only in IDLE. The grant is a level
// that covers ADDR through the done cycle. bus_req stays high in ADDR until the
// cycle in which bus_ack is seen. Each bus_rvalid cycle carries exactly one beat.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    output logic              mem_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_len,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_last,
    output logic              protocol_err,
    output logic [1:0]        dbg_state
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_WRESP = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            owner_if;    // 1: fetch owns the current transaction
    logic [7:0]      beat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            perr_q;
    logic            grant_mem, grant_if, final_beat, is_store;
    logic [7:0]      cur_len;

    // Data side wins unless fetch has already been passed over STARVE_MAX times.
    assign grant_mem  = mem_req && (!if_req || (starve_cnt < SW'(STARVE_MAX)));
    assign grant_if   = if_req && !grant_mem;
    assign cur_len    = owner_if ? 8'(LINE_BEATS - 1) : 8'd0;
    assign is_store   = !owner_if && mem_we;
    assign final_beat = (state == S_DATA) && bus_rvalid && (beat_cnt == cur_len);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_mem || grant_if) state_nxt = S_ADDR;
            S_ADDR:  if (bus_ack) state_nxt = is_store ? S_WRESP : S_DATA;
            S_DATA:  if (final_beat) state_nxt = S_IDLE;
            S_WRESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Owner, beat counter, starvation counter and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_if   <= 1'b0;
            beat_cnt   <= 8'd0;
            starve_cnt <= '0;
            perr_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_mem)     owner_if <= 1'b0;
                    else if (grant_if) owner_if <= 1'b1;
                    // Counts only data grants that made fetch wait.
                    if (!if_req || grant_if)
                        starve_cnt <= '0;
                    else if (grant_mem && (starve_cnt < SW'(STARVE_MAX)))
                        starve_cnt <= starve_cnt + 1'b1;
                end
                S_DATA: begin
                    if (bus_rvalid) begin
                        beat_cnt <= final_beat ? 8'd0 : beat_cnt + 8'd1;
                        // The count decides the end; bus_last is only cross-checked.
                        if (bus_last != final_beat) perr_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        if_gnt     = 1'b0;
        mem_gnt    = 1'b0;
        if_rdata   = '0;
        if_rvalid  = 1'b0;
        if_done    = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        mem_done   = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_len    = 8'd0;
        bus_wdata  = '0;
        if (state != S_IDLE) begin
            if_gnt  = owner_if;
            mem_gnt = !owner_if;
            bus_len = cur_len;
        end
        if (state == S_ADDR) begin
            bus_req   = 1'b1;
            bus_we    = is_store;
            bus_addr  = owner_if ? if_addr : mem_addr;
            bus_wdata = is_store ? mem_wdata : '0;
        end
        if (state == S_DATA && bus_rvalid) begin
            if (owner_if) begin
                if_rvalid = 1'b1;
                if_rdata  = bus_rdata;
                if_done   = final_beat;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = bus_rdata;
                mem_done   = final_beat;
            end
        end
        if (state == S_WRESP) mem_done = 1'b1;
        protocol_err = perr_q;
        dbg_state    = state;
    end

endmodule
